// File: rtl/switch_debounce.sv
// Slide-switch reader: 2-FF synchronizer, per-bit debounce counter and a
// buffered change-event register handed to the consumer over valid/ready.
module switch_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_mask,
  output logic [WIDTH-1:0] evt_data,
  output logic             evt_ovf
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic             r_evt_valid;
  logic [WIDTH-1:0] r_evt_mask;
  logic [WIDTH-1:0] r_evt_data;
  logic             r_evt_ovf;

  logic [WIDTH-1:0] w_commit_mask;
  logic [WIDTH-1:0] w_new_stable;
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic             w_evt_free;
  logic             w_evt_valid_next;
  logic [WIDTH-1:0] w_evt_mask_next;
  logic             w_evt_ovf_next;

  // Per-bit debounce: count cycles the synced level disagrees with the stable one.
  always_comb begin
    w_commit_mask = '0;
    w_new_stable  = r_stable;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = '0;
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == CNT_MAX) begin
        w_commit_mask[i] = 1'b1;
        w_new_stable[i]  = r_sync2[i];
        w_cnt_next[i]    = '0;
      end else begin
        w_cnt_next[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // Free slot takes this cycle's commits as a fresh event; a stalled slot merges them.
  always_comb begin
    w_evt_free       = ~r_evt_valid | evt_ready;
    w_evt_valid_next = 1'b0;
    w_evt_mask_next  = '0;
    w_evt_ovf_next   = 1'b0;
    if (w_evt_free) begin
      w_evt_valid_next = |w_commit_mask;
      w_evt_mask_next  = w_commit_mask;
      w_evt_ovf_next   = 1'b0;
    end else begin
      w_evt_valid_next = 1'b1;
      w_evt_mask_next  = r_evt_mask | w_commit_mask;
      w_evt_ovf_next   = r_evt_ovf | (|(r_evt_mask & w_commit_mask));
    end
  end

  // Synchronizer, debounce state and stable levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= sw_in;
      r_sync2  <= r_sync1;
      r_stable <= w_new_stable;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  // Event register; evt_data tracks the stable levels so it matches sw_stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_evt_valid <= 1'b0;
      r_evt_mask  <= '0;
      r_evt_data  <= '0;
      r_evt_ovf   <= 1'b0;
    end else begin
      r_evt_valid <= w_evt_valid_next;
      r_evt_mask  <= w_evt_mask_next;
      r_evt_data  <= w_new_stable;
      r_evt_ovf   <= w_evt_ovf_next;
    end
  end

  assign sw_stable = r_stable;
  assign evt_valid = r_evt_valid;
  assign evt_mask  = r_evt_mask;
  assign evt_data  = r_evt_data;
  assign evt_ovf   = r_evt_ovf;

endmodule
